// File: rtl/instr_encoder.sv
// instr_encoder: packs I/S/B-type fields into a 32-bit RISC-V word behind one
// output register stage. Optional IMM_RANGE_CHECK_EN flags out-of-range immediates.
module instr_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic [31:0] addr,
    output logic        err,
    output logic [7:0]  err_cnt,
    input  logic        addr_set,
    input  logic [31:0] addr_init
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic        xfer_in;
    logic        xfer_out;
    logic        held;
    logic        is_i;
    logic        is_s;
    logic        is_b;
    logic        i_range_bad;
    logic        b_range_bad;
    logic [31:0] enc_instr;
    logic        enc_err;
    logic        pend;
    logic [31:0] pend_addr;
    logic [31:0] init_al;

    assign in_ready = !out_valid || out_ready;
    assign xfer_in  = in_valid && in_ready;
    assign xfer_out = out_valid && out_ready;
    assign held     = out_valid && !out_ready;
    assign init_al  = {addr_init[31:2], 2'b00};

    assign is_i = (opcode == OP_LOAD) || (opcode == OP_IMM);
    assign is_s = (opcode == OP_STORE);
    assign is_b = (opcode == OP_BRANCH);

`ifdef IMM_RANGE_CHECK_EN
    assign i_range_bad = !((&imm[31:11]) || !(|imm[31:11]));
    assign b_range_bad = imm[0] || !((&imm[31:12]) || !(|imm[31:12]));
`else
    assign i_range_bad = 1'b0;
    assign b_range_bad = 1'b0;
`endif

    // Field packing per format; any error forces an all-zero word.
    always_comb begin
        enc_instr = '0;
        enc_err   = 1'b0;
        unique case (1'b1)
            is_i: begin
                enc_instr = {imm[11:0], rs1, funct3, rd, opcode};
                enc_err   = i_range_bad;
            end
            is_s: begin
                enc_instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                enc_err   = i_range_bad;
            end
            is_b: begin
                enc_instr = {imm[12], imm[10:5], rs2, rs1, funct3,
                             imm[4:1], imm[11], opcode};
                enc_err   = b_range_bad;
            end
            default: enc_err = 1'b1;
        endcase
        if (enc_err) begin
            enc_instr = '0;
        end
    end

    // Output register: capture on input transfer, drop valid once consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            instr     <= '0;
            err       <= 1'b0;
        end else if (xfer_in) begin
            out_valid <= 1'b1;
            instr     <= enc_instr;
            err       <= enc_err;
        end else if (xfer_out) begin
            out_valid <= 1'b0;
        end
    end

    // Address tag: a reload during a stall is parked until the held word leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr      <= '0;
            pend      <= 1'b0;
            pend_addr <= '0;
        end else if (addr_set) begin
            if (held) begin
                pend      <= 1'b1;
                pend_addr <= init_al;
            end else begin
                addr <= init_al;
                pend <= 1'b0;
            end
        end else if (xfer_out) begin
            addr <= pend ? pend_addr : addr + 32'd4;
            pend <= 1'b0;
        end
    end

    // Saturating count of erroneous words handed to the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (xfer_out && err && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: randomized + directed stimulus, scoreboard queue and an
// independent monitor comparing every consumed word against a reference model.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
    logic [7:0]  err_cnt;
    logic        addr_set;
    logic [31:0] addr_init;

    instr_encoder dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
        .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
        .instr(instr), .addr(addr), .err(err), .err_cnt(err_cnt),
        .addr_set(addr_set), .addr_init(addr_init)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        err;
        logic [31:0] addr;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          model_cnt = 0;
    logic [31:0] next_tag = 0;
    logic        set_seen = 0;
    logic [31:0] set_val = 0;
    int          rdy_mode = 0;
    logic        held_prev = 0;
    logic [31:0] prev_instr;
    logic [31:0] prev_addr;
    logic        prev_err;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: build the word from the ISA field layout, range by value.
    function automatic exp_t ref_enc(input logic [6:0] op, input logic [4:0] d,
                                     input logic [4:0] s1, input logic [4:0] s2,
                                     input logic [2:0] f3, input logic [31:0] im);
        exp_t e;
        int   v;
        logic bad;
        v = $signed(im);
        e.instr = 0;
        e.err = 0;
        e.addr = 0;
        bad = 0;
        if (op == 7'h03 || op == 7'h13 || op == 7'h23) begin
`ifdef IMM_RANGE_CHECK_EN
            bad = (v < -2048) || (v > 2047);
`endif
            if (op == 7'h23)
                e.instr = {im[11:5], s2, s1, f3, im[4:0], op};
            else
                e.instr = {im[11:0], s1, f3, d, op};
        end else if (op == 7'h63) begin
`ifdef IMM_RANGE_CHECK_EN
            bad = (v < -4096) || (v > 4095) || (v % 2 != 0);
`endif
            e.instr = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
        end else begin
            bad = 1;
        end
        if (bad) begin
            e.instr = 0;
            e.err = 1;
        end
        return e;
    endfunction

    function automatic logic pick_rdy(input int t, input int stall);
        if (t < stall) return 1'b0;
        if (rdy_mode == 1) return 1'b1;
        if (rdy_mode == 2) return 1'b0;
        return $urandom_range(0, 3) != 0;
    endfunction

    // Monitor: pops one expectation per consumed word, checks handshake and hold.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", {31'b0, in_ready}, {31'b0, (!out_valid || out_ready)});
            if (held_prev) begin
                chk("hold_valid", {31'b0, out_valid}, 32'd1);
                chk("hold_instr", instr, prev_instr);
                chk("hold_addr", addr, prev_addr);
                chk("hold_err", {31'b0, err}, {31'b0, prev_err});
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_word", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("instr", instr, e.instr);
                    chk("err", {31'b0, err}, {31'b0, e.err});
                    chk("addr", addr, e.addr);
                    chk("err_cnt", {24'b0, err_cnt}, model_cnt);
                    if (e.err && model_cnt < 255) model_cnt++;
                end
            end
            held_prev = out_valid && !out_ready;
            prev_instr = instr;
            prev_addr = addr;
            prev_err = err;
        end else begin
            held_prev = 0;
        end
    end

    task automatic note_set();
        if (addr_set) begin
            set_seen = 1;
            set_val = {addr_init[31:2], 2'b00};
        end
    endtask

    // Drive one request until accepted; records expectation at acceptance.
    task automatic issue(input logic [6:0] op, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2,
                         input logic [2:0] f3, input logic [31:0] im,
                         input logic set, input logic [31:0] init,
                         input int stall, input logic use_lit,
                         input logic [31:0] lit_instr, input logic lit_err);
        exp_t e;
        int   t;
        logic fired;
        opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; imm = im;
        addr_set = set; addr_init = init;
        in_valid = 1;
        out_ready = pick_rdy(0, stall);
        t = 0;
        fired = 0;
        while (!fired) begin
            @(negedge clk);
            note_set();
            if (in_valid && in_ready) begin
                e = ref_enc(op, d, s1, s2, f3, im);
                if (use_lit) begin
                    e.instr = lit_instr;
                    e.err = lit_err;
                end
                e.addr = set_seen ? set_val : next_tag;
                set_seen = 0;
                next_tag = e.addr + 32'd4;
                q.push_back(e);
                fired = 1;
            end
            @(posedge clk);
            #1;
            addr_set = 0;
            t++;
            out_ready = pick_rdy(t, stall);
            if (!fired && t > 200) begin
                chk("accept_timeout", 32'd1, 32'd0);
                fired = 1;
            end
        end
        chk("latency_valid", {31'b0, out_valid}, 32'd1);
        in_valid = 0;
    endtask

    task automatic set_addr(input logic [31:0] v);
        addr_set = 1;
        addr_init = v;
        @(negedge clk);
        note_set();
        @(posedge clk);
        #1;
        addr_set = 0;
    endtask

    task automatic drain();
        int t;
        out_ready = 1;
        t = 0;
        while ((q.size() != 0 || out_valid) && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 100) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 0;
        #1;
        q.delete();
        model_cnt = 0;
        next_tag = 0;
        set_seen = 0;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_instr", instr, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_err_cnt", {24'b0, err_cnt}, 32'd0);
        chk("rst_addr", addr, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    initial begin
        logic [6:0]  op;
        logic [31:0] im;
        logic [6:0]  opt;
        rst_n = 1; in_valid = 0; out_ready = 1; addr_set = 0; addr_init = 0;
        opcode = 0; rd = 0; rs1 = 0; rs2 = 0; funct3 = 0; imm = 0;
        #12;
        do_reset();

        rdy_mode = 1;
        set_addr(32'h0);
        issue(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 0, 0, 0, 1, 32'h00500093, 0);
        issue(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8, 0, 0, 0, 1, 32'h0020A423, 0);
        issue(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, -32'sd4, 0, 0, 0, 1, 32'hFE000EE3, 0);
`ifdef IMM_RANGE_CHECK_EN
        issue(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048, 0, 0, 0, 1, 32'h0, 1);
        issue(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'd6, 0, 0, 0, 1, 32'h0, 1);
`else
        issue(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048, 0, 0, 0, 1, 32'h80000093, 0);
`endif
        issue(7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 32'd1, 0, 0, 0, 1, 32'h0, 1);
        drain();

        set_addr(32'hFFFFFFF6);
        issue(7'h03, 5'd3, 5'd4, 5'd0, 3'd2, 32'd16, 0, 0, 0, 0, 0, 0);
        issue(7'h13, 5'd5, 5'd6, 5'd0, 3'd0, -32'sd1, 0, 0, 3, 0, 0, 0);
        issue(7'h23, 5'd0, 5'd7, 5'd8, 3'd1, 32'd20, 0, 0, 3, 0, 0, 0);
        issue(7'h63, 5'd0, 5'd9, 5'd10, 3'd1, 32'd64, 1, 32'h1000, 3, 0, 0, 0);
        issue(7'h13, 5'd11, 5'd12, 5'd0, 3'd7, 32'd100, 0, 0, 0, 0, 0, 0);
        drain();

        rdy_mode = 0;
        for (int i = 0; i < 1200; i++) begin
            opt = 7'($urandom_range(0, 7));
            case (opt)
                0: op = 7'h03;
                1: op = 7'h13;
                2: op = 7'h23;
                3: op = 7'h63;
                4: op = 7'h13;
                default: op = 7'($urandom);
            endcase
            if ($urandom_range(0, 3) == 0) im = $urandom;
            else im = 32'($signed(13'($urandom)));
            issue(op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
                  im, $urandom_range(0, 19) == 0, $urandom, 0, 0, 0, 0);
        end
        drain();

        rdy_mode = 2;
        issue(7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 32'd1, 0, 0, 0, 0, 0, 0);
        #3;
        do_reset();
        rdy_mode = 1;
        issue(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 32'd7, 0, 0, 0, 0, 0, 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001: clk  input  1  single clock; all state updates on rising edge.
REQ-002: rst_n  input  1  asynchronous, active-low reset.
REQ-003: in_valid  input  1  request fields valid.
REQ-004: in_ready  output  1  encoder can accept a request this cycle.
REQ-005: opcode  input  7  instruction opcode: 0000011/0010011 I-type, 0100011 S-type, 1100011 B-type.
REQ-006: rd, rs1, rs2  input  5 each  register indices; unused fields ignored per format.
REQ-007: funct3  input  3  funct3 field.
REQ-008: imm  input  32  signed immediate, byte offset for B-type.
REQ-009: out_valid  output  1  encoded word valid.
REQ-010: out_ready  input  1  consumer accepts word.
REQ-011: instr  output  32  encoded instruction.
REQ-012: addr  output  32  byte address tagged to current instr.
REQ-013: err  output  1  current word invalid (unsupported opcode or immediate out of range).
REQ-014: err_cnt  output  8  count of transferred words with err=1.
REQ-015: addr_set  input  1  load address counter.
REQ-016: addr_init  input  32  value loaded on addr_set; bits [1:0] forced to 0.

Function
REQ-017: Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-018: Single output register stage; in_ready = !out_valid || out_ready (combinational); latency exactly 1 cycle from input transfer to out_valid.
REQ-019: out_valid, instr, addr, err SHALL hold stable while out_valid && !out_ready.
REQ-020: I-type: instr = {imm[11:0], rs1, funct3, rd, opcode}.
REQ-021: S-type: instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
REQ-022: B-type: instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
REQ-023: Any other opcode: instr = 32'h0, err = 1.
REQ-024: Whenever err = 1, instr SHALL be 32'h0.
REQ-025: addr counter increments by 4 on each output transfer; wraps 32'hFFFFFFFC -> 32'h0.
REQ-026: addr_set loads addr_init next cycle; if addr_set coincides with an output transfer, addr_set wins (no increment).
REQ-027: addr_set while out_valid && !out_ready SHALL NOT change the tag of the held word until it transfers; the new value tags the next word.
REQ-028: err_cnt increments on output transfer with err = 1; saturates at 8'hFF.
REQ-029: Back-to-back transfers at full throughput (one per cycle) SHALL be supported when out_ready stays high.

Reset
REQ-030: rst_n low asynchronously clears out_valid, instr, err, err_cnt and addr to 0; in_ready is 1 during and after reset.
REQ-031: Reset mid-transfer discards the held word; no partial state survives.

Configuration
REQ-032: Macro IMM_RANGE_CHECK_EN defined: I/S err when imm[31:11] not all equal; B err when imm[0] != 0 or imm[31:12] not all equal.
REQ-033: Macro undefined: no range check; immediate bits truncated per REQ-020..022; err only per REQ-023.

Verification
REQ-034: opcode=0010011, rd=1, rs1=0, funct3=0, imm=5, addr_set with addr_init=0 beforehand -> next cycle instr=32'h00500093, addr=0, err=0.
REQ-035: opcode=0100011, rs1=1, rs2=2, funct3=010, imm=8 -> instr=32'h0020A423; following word addr=4.
REQ-036: opcode=1100011, rs1=0, rs2=0, funct3=0, imm=-4 -> instr=32'hFE000EE3, err=0.
REQ-037: I-type imm=2048: with IMM_RANGE_CHECK_EN -> err=1, instr=0, err_cnt+1; without -> instr=32'h80000093 (rd=1), err=0.
REQ-038: out_ready low 3 cycles with in_valid high -> in_ready=0, instr/addr held; then out_ready high -> one word per cycle, addr steps by 4, 32'hFFFFFFFC wraps to 0.
REQ-039: Assert rst_n low while out_valid=1 -> out_valid=0, err_cnt=0, addr=0 immediately, without waiting for a clock edge.
